// File: rtl/cfg_chain_loader.sv
// Streams bitstream words into NUM_CHAINS fabric config chains and generates prog_clk.
// Latency: 2*CLK_DIV clk per bit group, plus at least 1 fetch cycle per word; all outputs registered.
// Backpressure: wr_ready is high only in FETCH, and prog_clk is parked low while a word is awaited.
module cfg_chain_loader #(
    parameter int NUM_CHAINS     = 1,
    parameter int WORD_W         = 32,
    parameter int BITS_PER_CHAIN = 256,
    parameter int CLK_DIV        = 1,
    parameter int GRESET_CYCLES  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  verify,
    input  logic                  abort,
    input  logic                  wr_valid,
    input  logic [WORD_W-1:0]     wr_data,
    output logic                  wr_ready,
    input  logic [NUM_CHAINS-1:0] ccff_tail,
    output logic [NUM_CHAINS-1:0] ccff_head,
    output logic                  prog_clk,
    output logic                  busy,
    output logic                  done,
    output logic                  fabric_reset,
    output logic                  op_clk_en,
    output logic                  verify_err,
    output logic [31:0]           bit_count
);
    localparam int GROUPS = WORD_W / NUM_CHAINS;
    localparam int SHW    = $clog2(2 * BITS_PER_CHAIN + 1);
    localparam int GW     = $clog2(GROUPS + 1);
    localparam int DMAX   = (CLK_DIV > GRESET_CYCLES) ? CLK_DIV : GRESET_CYCLES;
    localparam int DW     = $clog2(DMAX + 1);

    localparam logic [SHW-1:0] PASS_LEN   = SHW'(BITS_PER_CHAIN);
    localparam logic [SHW-1:0] VERIFY_LEN = SHW'(2 * BITS_PER_CHAIN);
    localparam logic [GW-1:0]  GRP_INIT   = GW'(GROUPS);
    localparam logic [DW-1:0]  DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0]  GRST_LAST  = DW'(GRESET_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOW, S_HIGH, S_GRST, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic                    verify_mode_q, verify_mode_d;
    logic [WORD_W-1:0]       shreg_q, shreg_d;
    logic [GW-1:0]           grp_q, grp_d;
    logic [DW-1:0]           div_q, div_d;
    logic [SHW-1:0]          shift_cnt_q, shift_cnt_d;
    logic                    wr_ready_q, wr_ready_d;
    logic [NUM_CHAINS-1:0]   head_q, head_d;
    logic                    prog_clk_q, prog_clk_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    fabric_reset_q, fabric_reset_d;
    logic                    op_clk_en_q, op_clk_en_d;
    logic                    verify_err_q, verify_err_d;
    logic [31:0]             bit_count_q, bit_count_d;

    logic [WORD_W-1:0]       shreg_shr;
    logic [SHW-1:0]          shift_nxt;
    logic [SHW-1:0]          total_len;

    assign shreg_shr = shreg_q >> NUM_CHAINS;
    assign shift_nxt = shift_cnt_q + SHW'(1);
    assign total_len = verify_mode_q ? VERIFY_LEN : PASS_LEN;

    always_comb begin
        state_d        = state_q;
        verify_mode_d  = verify_mode_q;
        shreg_d        = shreg_q;
        grp_d          = grp_q;
        div_d          = div_q;
        shift_cnt_d    = shift_cnt_q;
        wr_ready_d     = wr_ready_q;
        head_d         = head_q;
        prog_clk_d     = prog_clk_q;
        busy_d         = busy_q;
        done_d         = done_q;
        fabric_reset_d = fabric_reset_q;
        op_clk_en_d    = op_clk_en_q;
        verify_err_d   = verify_err_q;
        bit_count_d    = bit_count_q;

        if (abort && state_q != S_IDLE) begin
            // bit_count and verify_err deliberately survive an abort for post-mortem
            state_d        = S_IDLE;
            wr_ready_d     = 1'b0;
            head_d         = '0;
            prog_clk_d     = 1'b0;
            busy_d         = 1'b0;
            done_d         = 1'b0;
            fabric_reset_d = 1'b0;
            op_clk_en_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d       = S_FETCH;
                        verify_mode_d = verify;
                        shift_cnt_d   = '0;
                        done_d        = 1'b0;
                        verify_err_d  = 1'b0;
                        bit_count_d   = '0;
                        op_clk_en_d   = 1'b0;
                        wr_ready_d    = 1'b1;
                        busy_d        = 1'b1;
                    end
                end
                S_FETCH: begin
                    if (wr_valid) begin
                        state_d    = S_LOW;
                        shreg_d    = wr_data;
                        grp_d      = GRP_INIT;
                        div_d      = '0;
                        wr_ready_d = 1'b0;
                        head_d     = wr_data[NUM_CHAINS-1:0];
                    end
                end
                S_LOW: begin
                    if (div_q == DIV_LAST) begin
                        // second pass: tail now carries the matching bit from pass one
                        if (verify_mode_q && shift_cnt_q >= PASS_LEN && ccff_tail != head_q)
                            verify_err_d = 1'b1;
                        state_d     = S_HIGH;
                        div_d       = '0;
                        prog_clk_d  = 1'b1;
                        bit_count_d = (&bit_count_q) ? bit_count_q : bit_count_q + 32'd1;
                    end else begin
                        div_d = div_q + DW'(1);
                    end
                end
                S_HIGH: begin
                    if (div_q == DIV_LAST) begin
                        shreg_d     = shreg_shr;
                        grp_d       = grp_q - GW'(1);
                        shift_cnt_d = shift_nxt;
                        div_d       = '0;
                        prog_clk_d  = 1'b0;
                        if (shift_nxt == total_len) begin
                            state_d        = S_GRST;
                            head_d         = '0;
                            fabric_reset_d = 1'b1;
                        end else if (shift_nxt == PASS_LEN || grp_q == GW'(1)) begin
                            // a pass boundary drops the rest of the word
                            state_d    = S_FETCH;
                            wr_ready_d = 1'b1;
                        end else begin
                            state_d = S_LOW;
                            head_d  = shreg_shr[NUM_CHAINS-1:0];
                        end
                    end else begin
                        div_d = div_q + DW'(1);
                    end
                end
                S_GRST: begin
                    if (div_q == GRST_LAST) begin
                        state_d        = S_DONE;
                        fabric_reset_d = 1'b0;
                        done_d         = 1'b1;
                        op_clk_en_d    = 1'b1;
                        busy_d         = 1'b0;
                    end else begin
                        div_d = div_q + DW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            verify_mode_q  <= 1'b0;
            shreg_q        <= '0;
            grp_q          <= '0;
            div_q          <= '0;
            shift_cnt_q    <= '0;
            wr_ready_q     <= 1'b0;
            head_q         <= '0;
            prog_clk_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            fabric_reset_q <= 1'b0;
            op_clk_en_q    <= 1'b0;
            verify_err_q   <= 1'b0;
            bit_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            verify_mode_q  <= verify_mode_d;
            shreg_q        <= shreg_d;
            grp_q          <= grp_d;
            div_q          <= div_d;
            shift_cnt_q    <= shift_cnt_d;
            wr_ready_q     <= wr_ready_d;
            head_q         <= head_d;
            prog_clk_q     <= prog_clk_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            fabric_reset_q <= fabric_reset_d;
            op_clk_en_q    <= op_clk_en_d;
            verify_err_q   <= verify_err_d;
            bit_count_q    <= bit_count_d;
        end
    end

    assign wr_ready     = wr_ready_q;
    assign ccff_head    = head_q;
    assign prog_clk     = prog_clk_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign fabric_reset = fabric_reset_q;
    assign op_clk_en    = op_clk_en_q;
    assign verify_err   = verify_err_q;
    assign bit_count    = bit_count_q;

endmodule
